// File: rtl/datapath_unit_pkg.sv
// Shared widths and ALU opcode encodings for the datapath unit and its ALU.
package datapath_unit_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [3:0] {
        OP_PASS_A = 4'b0000,
        OP_ADD    = 4'b0001,
        OP_ADD_NB = 4'b0010,
        OP_AND    = 4'b0011,
        OP_SUB    = 4'b0100,
        OP_OR     = 4'b0101,
        OP_XOR    = 4'b0110,
        OP_INC_A  = 4'b0111,
        OP_NOT_A  = 4'b1000,
        OP_SHL_A  = 4'b1001,
        OP_MUL    = 4'b1010,
        OP_SHR_A  = 4'b1011
    } alu_op_e;

    // Carry-in as a full-width addend so every sum stays in DATA_W bits.
    function automatic word_t cin_word(input logic cin);
        return {{(DATA_W-1){1'b0}}, cin};
    endfunction

endpackage

// File: rtl/datapath_unit_alu.sv
// 16-bit ALU: arithmetic, logic, shift and low-half multiply.
// Latency: purely combinational.
// Backpressure: none; output follows inputs continuously.
module dp_alu
    import datapath_unit_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] y
);

    word_t cin_w;
    assign cin_w = cin_word(cin);

    // All results truncate to DATA_W; carries and upper product bits are dropped.
    always_comb begin
        y = '0;
        case (op)
            OP_PASS_A: y = a;
            OP_ADD:    y = a + b + cin_w;
            OP_ADD_NB: y = a + ~b + cin_w;
            OP_AND:    y = a & b;
            OP_SUB:    y = a - b - cin_w;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_INC_A:  y = a + word_t'(1);
            OP_NOT_A:  y = ~a;
            OP_SHL_A:  y = {a[DATA_W-2:0], 1'b0};
            OP_MUL:    y = a * b;
            OP_SHR_A:  y = {1'b0, a[DATA_W-1:1]};
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/datapath_unit.sv
// Register file + ALU + output register datapath driven by an external controller.
// Latency: reads/Datapath combinational; register writes and Data_out one CLK.
// Backpressure: none; every cycle's controls are acted on unconditionally.
module datapath_unit
    import datapath_unit_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              IE,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic              REA,
    input  logic [ADDR_W-1:0] RAA,
    input  logic              REB,
    input  logic [ADDR_W-1:0] RAB,
    input  logic [3:0]        S_ALU,
    input  logic              Cin,
    input  logic              OE,
    output logic [DATA_W-1:0] Data_out,
    output logic [DATA_W-1:0] Datapath
);

    word_t regs [NUM_REGS];
    word_t bus_a;
    word_t bus_b;
    word_t alu_y;

    // R0 is hardwired to zero on read, so its storage is never consulted.
    assign bus_a = (REA && (RAA != '0)) ? regs[RAA] : '0;
    assign bus_b = (REB && (RAB != '0)) ? regs[RAB] : '0;

    dp_alu u_alu (
        .a   (bus_a),
        .b   (bus_b),
        .cin (Cin),
        .op  (S_ALU),
        .y   (alu_y)
    );

    assign Datapath = IE ? Data_in : alu_y;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (WE && (WA != '0)) begin
            regs[WA] <= Datapath;
        end
    end

    // Output register takes the ALU result, never the external operand.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)     Data_out <= '0;
        else if (OE) Data_out <= alu_y;
    end

endmodule

// File: tb/tb_datapath_unit.sv
module tb_datapath_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] Data_in;
    logic        IE, WE, REA, REB, Cin, OE;
    logic [3:0]  WA, RAA, RAB, S_ALU;
    logic [15:0] Data_out, Datapath;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    datapath_unit dut (
        .CLK      (CLK),
        .RST      (RST),
        .Data_in  (Data_in),
        .IE       (IE),
        .WE       (WE),
        .WA       (WA),
        .REA      (REA),
        .RAA      (RAA),
        .REB      (REB),
        .RAB      (RAB),
        .S_ALU    (S_ALU),
        .Cin      (Cin),
        .OE       (OE),
        .Data_out (Data_out),
        .Datapath (Datapath)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        Data_in = 16'h0; IE = 0; WE = 0; WA = 0;
        REA = 0; RAA = 0; REB = 0; RAB = 0;
        S_ALU = 4'b0000; Cin = 0; OE = 0;
    endtask

    task automatic write_ext(input logic [3:0] addr, input logic [15:0] val);
        idle();
        IE = 1; Data_in = val; WE = 1; WA = addr;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        RST = 1;
        #3;
        chk_cnt++;
        if (Data_out !== 16'h0) $display("FAIL reset_dout: got %h expected 0000", Data_out);
        else pass_cnt++;
        REA = 1; RAA = 4'd7;
        #1;
        chk_cnt++;
        if (Datapath !== 16'h0) $display("FAIL reset_reg: got %h expected 0000", Datapath);
        else pass_cnt++;
        tick();
        #3 RST = 0;
        idle();
    endtask

    task automatic test_r0();
        write_ext(4'd0, 16'hFFFF);
        REA = 1; RAA = 4'd0; S_ALU = 4'b0000;
        #1;
        chk_cnt++;
        if (Datapath !== 16'h0000) $display("FAIL r0_read: got %h expected 0000", Datapath);
        else pass_cnt++;
        write_ext(4'd9, 16'h5A5A);
        REA = 0; RAA = 4'd9;
        #1;
        chk_cnt++;
        if (Datapath !== 16'h0000) $display("FAIL read_disabled: got %h expected 0000", Datapath);
        else pass_cnt++;
        REA = 1;
        #1;
        chk_cnt++;
        if (Datapath !== 16'h5A5A) $display("FAIL read_enabled: got %h expected 5a5a", Datapath);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_alu_sweep();
        logic [15:0] exp_tbl [16];
        exp_tbl[0]  = 16'h8001; exp_tbl[1]  = 16'h8101;
        exp_tbl[2]  = 16'h7F02; exp_tbl[3]  = 16'h0001;
        exp_tbl[4]  = 16'h7F01; exp_tbl[5]  = 16'h80FF;
        exp_tbl[6]  = 16'h80FE; exp_tbl[7]  = 16'h8002;
        exp_tbl[8]  = 16'h7FFE; exp_tbl[9]  = 16'h0002;
        exp_tbl[10] = 16'h80FF; exp_tbl[11] = 16'h4000;
        exp_tbl[12] = 16'h0000; exp_tbl[13] = 16'h0000;
        exp_tbl[14] = 16'h0000; exp_tbl[15] = 16'h0000;
        write_ext(4'd1, 16'h8001);
        write_ext(4'd2, 16'h00FF);
        REA = 1; RAA = 4'd1; REB = 1; RAB = 4'd2; Cin = 1;
        for (int op = 0; op < 16; op++) begin
            S_ALU = op[3:0];
            #1;
            chk_cnt++;
            if (Datapath !== exp_tbl[op])
                $display("FAIL alu_op_%0d: got %h expected %h", op, Datapath, exp_tbl[op]);
            else pass_cnt++;
        end
        idle();
    endtask

    task automatic test_factorial(input logic [15:0] n, input logic [15:0] expv);
        logic done;
        idle();
        REA = 1; RAA = 4'd0; S_ALU = 4'b0111; WE = 1; WA = 4'd3;
        tick();
        idle();
        IE = 1; Data_in = n; WE = 1; WA = 4'd1;
        tick();
        idle();
        done = 0;
        for (int it = 0; it < 20 && !done; it++) begin
            REA = 1; RAA = 4'd1; REB = 1; RAB = 4'd3; S_ALU = 4'b1010; Cin = 0;
            WE = 1; WA = 4'd3;
            tick();
            REB = 0; S_ALU = 4'b0100; Cin = 1; WA = 4'd1;
            #1;
            if (Datapath === 16'h0001) done = 1;
            tick();
        end
        chk_cnt++;
        if (!done) $display("FAIL fact_loop_%0d: got no termination expected Datapath=0001", n);
        else pass_cnt++;
        idle();
        REA = 1; RAA = 4'd3; S_ALU = 4'b0101; OE = 1;
        tick();
        idle();
        #1;
        chk_cnt++;
        if (Data_out !== expv) $display("FAIL fact_%0d: got %h expected %h", n, Data_out, expv);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        write_ext(4'd2, 16'h0011);
        IE = 1; Data_in = 16'h0022; WE = 1; WA = 4'd2;
        REA = 1; RAA = 4'd2; S_ALU = 4'b0000; OE = 1;
        #1;
        chk_cnt++;
        if (Datapath !== 16'h0022) $display("FAIL coll_bus: got %h expected 0022", Datapath);
        else pass_cnt++;
        tick();
        idle();
        REA = 1; RAA = 4'd2;
        #1;
        chk_cnt++;
        if (Data_out !== 16'h0011) $display("FAIL coll_old_read: got %h expected 0011", Data_out);
        else pass_cnt++;
        chk_cnt++;
        if (Datapath !== 16'h0022) $display("FAIL coll_new_read: got %h expected 0022", Datapath);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (Data_out !== 16'h0011) $display("FAIL oe_hold: got %h expected 0011", Data_out);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_reset_midrun();
        write_ext(4'd5, 16'h1234);
        REA = 1; RAA = 4'd5; OE = 1;
        tick();
        chk_cnt++;
        if (Data_out !== 16'h1234) $display("FAIL pre_reset_dout: got %h expected 1234", Data_out);
        else pass_cnt++;
        IE = 1; Data_in = 16'hBEEF; WE = 1; WA = 4'd6; OE = 1;
        #2 RST = 1;
        IE = 0;
        #1;
        chk_cnt++;
        if (Datapath !== 16'h0000) $display("FAIL reset_r5: got %h expected 0000", Datapath);
        else pass_cnt++;
        chk_cnt++;
        if (Data_out !== 16'h0000) $display("FAIL reset_dout_async: got %h expected 0000", Data_out);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (Data_out !== 16'h0000) $display("FAIL reset_hold: got %h expected 0000", Data_out);
        else pass_cnt++;
        #3 RST = 0;
        idle();
        IE = 1; Data_in = 16'hA5A5; WE = 1; WA = 4'd7;
        tick();
        idle();
        REA = 1; RAA = 4'd7;
        #1;
        chk_cnt++;
        if (Datapath !== 16'hA5A5) $display("FAIL first_write: got %h expected a5a5", Datapath);
        else pass_cnt++;
        RAA = 4'd6;
        #1;
        chk_cnt++;
        if (Datapath !== 16'h0000) $display("FAIL lost_write: got %h expected 0000", Datapath);
        else pass_cnt++;
        idle();
    endtask

    initial begin
        idle();
        RST = 0;
        test_reset();
        test_r0();
        test_alu_sweep();
        test_factorial(16'd5, 16'h0078);
        test_factorial(16'd8, 16'h9D80);
        test_factorial(16'd9, 16'h8980);
        test_collision();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
